// File: rtl/ccc_apb_reconfig_seq_if.sv
// rtl/ccc_apb_reconfig_seq_if.sv - APB (8-bit data, PADDR[7:2]) link between reconfig sequencer and CCC slave
//
// Signals:
//   PSEL, PENABLE, PWRITE  master -> slave transfer controls
//   PADDR[5:0]             register address bits [7:2]
//   PWDATA[7:0]            write byte
//   PRDATA[7:0]            read byte, slave -> master
//   PREADY, PSLVERR        slave completion and error response
// Modports: master (sequencer side), slave (CCC side).

interface ccc_apb_reconfig_seq_if;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [5:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;
    logic       PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/ccc_apb_reconfig_seq.sv
// rtl/ccc_apb_reconfig_seq.sv - APB master that reprograms a CCC/PLL from a software-loaded table
//
// Holds the PLL in reset, writes every (address, data) table entry over APB,
// optionally reads them back, releases the PLL reset and waits for a stable LOCK.
//
// Optional feature: define CCC_RECFG_VERIFY_EN to add a read-back pass after the
// writes (mismatch reports ERR_CODE 3). Without it the write pass goes straight
// to the lock wait.
//
// Ports:
//   APB_S_PCLK, APB_S_PRESET_N  clock, asynchronous active-low reset
//   TBL_WE/TBL_IDX/TBL_ADDR/TBL_DATA  table load port (ignored while BUSY)
//   START                       single-cycle start request
//   BUSY, DONE, ERR, ERR_CODE   status: busy level, success pulse, sticky error + code
//   apb_m                       APB master port (PSEL/PENABLE/PWRITE/PADDR/PWDATA out)
//   PLL_ARST_N                  PLL reset, active low; released only by a good sequence
//   LOCK                        asynchronous CCC lock, 2-flop synchronised here

module ccc_apb_reconfig_seq #(
    parameter int NUM_REGS     = 8,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_STABLE  = 64,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic                           APB_S_PCLK,
    input  logic                           APB_S_PRESET_N,
    input  logic                           TBL_WE,
    input  logic [4:0]                     TBL_IDX,
    input  logic [5:0]                     TBL_ADDR,
    input  logic [7:0]                     TBL_DATA,
    input  logic                           START,
    output logic                           BUSY,
    output logic                           DONE,
    output logic                           ERR,
    output logic [1:0]                     ERR_CODE,
    ccc_apb_reconfig_seq_if.master         apb_m,
    output logic                           PLL_ARST_N,
    input  logic                           LOCK
);

    localparam int IW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int DEPTH = 1 << IW;
    localparam int CMAX  = (LOCK_TIMEOUT > RST_HOLD)
                         ? ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE)
                         : ((RST_HOLD > LOCK_STABLE) ? RST_HOLD : LOCK_STABLE);
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);

    localparam logic [1:0] EC_NONE     = 2'd0;
    localparam logic [1:0] EC_SLVERR   = 2'd1;
    localparam logic [1:0] EC_TIMEOUT  = 2'd2;
`ifdef CCC_RECFG_VERIFY_EN
    localparam logic [1:0] EC_MISMATCH = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE, ST_HOLD_RST, ST_WR_SETUP, ST_WR_ACCESS,
        ST_RD_SETUP, ST_RD_ACCESS, ST_WAIT_LOCK, ST_FINISH
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_HOLD_RST, ST_WR_SETUP, ST_WR_ACCESS,
        ST_WAIT_LOCK, ST_FINISH
    } state_t;
`endif

    state_t          state, state_d;
    logic [IW-1:0]   idx, idx_d;
    logic [CW-1:0]   cnt, cnt_d;        // hold-reset count, then stable-lock count
    logic [CW-1:0]   tmo, tmo_d;
    logic [1:0]      err_code_q, code_d;
    logic            pll_q, pll_d;
    logic            lock_s1, lock_sync;
    logic            psel, penable, pwrite;

    // Table is plain storage with no reset; contents are undefined until loaded.
    logic [5:0] tbl_addr [DEPTH];
    logic [7:0] tbl_data [DEPTH];

    always_ff @(posedge APB_S_PCLK) begin
        // Guard against indices that would alias into the rounded-up storage.
        if (TBL_WE && !BUSY && (32'(TBL_IDX) < NUM_REGS)) begin
            tbl_addr[TBL_IDX[IW-1:0]] <= TBL_ADDR;
            tbl_data[TBL_IDX[IW-1:0]] <= TBL_DATA;
        end
    end

    always_ff @(posedge APB_S_PCLK or negedge APB_S_PRESET_N) begin
        if (!APB_S_PRESET_N) begin
            state      <= ST_IDLE;
            idx        <= '0;
            cnt        <= '0;
            tmo        <= '0;
            err_code_q <= EC_NONE;
            pll_q      <= 1'b0;
            lock_s1    <= 1'b0;
            lock_sync  <= 1'b0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            cnt        <= cnt_d;
            tmo        <= tmo_d;
            err_code_q <= code_d;
            pll_q      <= pll_d;
            lock_s1    <= LOCK;
            lock_sync  <= lock_s1;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        cnt_d   = cnt;
        tmo_d   = tmo;
        code_d  = err_code_q;
        pll_d   = pll_q;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    code_d  = EC_NONE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    pll_d   = 1'b0;
                    state_d = ST_HOLD_RST;
                end
            end
            ST_HOLD_RST: begin
                if (cnt == CW'(RST_HOLD - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_WR_SETUP;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            ST_WR_SETUP: state_d = ST_WR_ACCESS;
            ST_WR_ACCESS: begin
                if (apb_m.PREADY) begin
                    if (apb_m.PSLVERR) begin
                        code_d  = EC_SLVERR;
                        state_d = ST_FINISH;
                    end else if (idx != LAST_IDX) begin
                        idx_d   = idx + IW'(1);
                        state_d = ST_WR_SETUP;
                    end else begin
`ifdef CCC_RECFG_VERIFY_EN
                        idx_d   = '0;
                        state_d = ST_RD_SETUP;
`else
                        pll_d   = 1'b1;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = ST_WAIT_LOCK;
`endif
                    end
                end
            end
`ifdef CCC_RECFG_VERIFY_EN
            ST_RD_SETUP: state_d = ST_RD_ACCESS;
            ST_RD_ACCESS: begin
                if (apb_m.PREADY) begin
                    // A bus error outranks a data mismatch on the same beat.
                    if (apb_m.PSLVERR) begin
                        code_d  = EC_SLVERR;
                        state_d = ST_FINISH;
                    end else if (apb_m.PRDATA != tbl_data[idx]) begin
                        code_d  = EC_MISMATCH;
                        state_d = ST_FINISH;
                    end else if (idx != LAST_IDX) begin
                        idx_d   = idx + IW'(1);
                        state_d = ST_RD_SETUP;
                    end else begin
                        pll_d   = 1'b1;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end
                end
            end
`endif
            ST_WAIT_LOCK: begin
                // Qualification wins a tie with the timeout.
                if (lock_sync && (cnt == CW'(LOCK_STABLE - 1))) begin
                    state_d = ST_FINISH;
                end else if (tmo == CW'(LOCK_TIMEOUT - 1)) begin
                    code_d  = EC_TIMEOUT;
                    pll_d   = 1'b0;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = lock_sync ? (cnt + CW'(1)) : '0;
                    tmo_d = tmo + CW'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        case (state)
            ST_WR_SETUP:  begin psel = 1'b1; pwrite = 1'b1; end
            ST_WR_ACCESS: begin psel = 1'b1; penable = 1'b1; pwrite = 1'b1; end
`ifdef CCC_RECFG_VERIFY_EN
            ST_RD_SETUP:  psel = 1'b1;
            ST_RD_ACCESS: begin psel = 1'b1; penable = 1'b1; end
`endif
            default: ;
        endcase
    end

`ifndef CCC_RECFG_VERIFY_EN
    logic unused_prdata;
    assign unused_prdata = ^apb_m.PRDATA;
`endif

    assign apb_m.PSEL    = psel;
    assign apb_m.PENABLE = penable;
    assign apb_m.PWRITE  = pwrite;
    assign apb_m.PADDR   = psel ? tbl_addr[idx] : 6'd0;
    assign apb_m.PWDATA  = psel ? tbl_data[idx] : 8'd0;

    assign BUSY       = (state != ST_IDLE);
    assign DONE       = (state == ST_FINISH) && (err_code_q == EC_NONE);
    assign ERR        = (err_code_q != EC_NONE);
    assign ERR_CODE   = err_code_q;
    assign PLL_ARST_N = pll_q;

endmodule

// File: tb/tb_ccc_apb_reconfig_seq.sv
// tb/tb_ccc_apb_reconfig_seq.sv - table-driven bench for ccc_apb_reconfig_seq with APB slave and PLL lock model

module tb_ccc_apb_reconfig_seq;

    localparam int NR = 8;
    localparam int RH = 16;
    localparam int LS = 64;
    localparam int LT = 300;
`ifdef CCC_RECFG_VERIFY_EN
    localparam int VX = 2 * NR;
`else
    localparam int VX = 0;
`endif
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tbl_we;
    logic [4:0] tbl_idx;
    logic [5:0] tbl_addr;
    logic [7:0] tbl_data;
    logic       start;
    logic       busy, done, err, pll, lock;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    ccc_apb_reconfig_seq_if apb ();

    ccc_apb_reconfig_seq #(
        .NUM_REGS(NR), .RST_HOLD(RH), .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
    ) u_dut (
        .APB_S_PCLK    (clk),
        .APB_S_PRESET_N(rst_n),
        .TBL_WE        (tbl_we),
        .TBL_IDX       (tbl_idx),
        .TBL_ADDR      (tbl_addr),
        .TBL_DATA      (tbl_data),
        .START         (start),
        .BUSY          (busy),
        .DONE          (done),
        .ERR           (err),
        .ERR_CODE      (err_code),
        .apb_m         (apb),
        .PLL_ARST_N    (pll),
        .LOCK          (lock)
    );

    // APB slave model: optional wait states / PSLVERR on one written address,
    // optional corrupted read-back on one address.
    logic [5:0]  stall_addr = 6'h3F;
    logic [5:0]  err_addr   = 6'h3F;
    logic [5:0]  cor_addr   = 6'h3F;
    int          stall_n    = 3;
    int          acc        = 0;
    logic [7:0]  mem [64];
    logic [13:0] wlog [$];

    assign apb.PREADY  = apb.PSEL && apb.PENABLE &&
                         (acc >= ((apb.PWRITE && apb.PADDR == stall_addr) ? stall_n : 0));
    assign apb.PSLVERR = apb.PREADY && apb.PWRITE && (apb.PADDR == err_addr);
    assign apb.PRDATA  = mem[apb.PADDR] ^ ((apb.PADDR == cor_addr) ? 8'h40 : 8'h00);

    always @(posedge clk) begin
        if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc <= acc + 1;
        else                                        acc <= 0;
        if (apb.PSEL && apb.PENABLE && apb.PREADY && apb.PWRITE && !apb.PSLVERR) begin
            mem[apb.PADDR] <= apb.PWDATA;
            wlog.push_back({apb.PADDR, apb.PWDATA});
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    logic [5:0] taddr [NR];
    logic [7:0] tdata [NR];

    typedef struct {
        int stall_e;   // entry with 3 write wait states, -1 none
        int err_e;     // entry answered with PSLVERR, -1 none
        int cor_e;     // entry whose read-back is corrupted, -1 none
        int ld;        // cycles after PLL release until LOCK rises
        int glitch;    // PLL-release-relative cycle where LOCK drops for one cycle, -1 none
        int poke;      // 1: START + table write while busy
        int exp_done;
        int exp_code;
        int exp_cyc;   // cycle of DONE/ERR relative to the START cycle
        int exp_wr;
        int exp_acc;   // write access cycles seen on entry 2
        int exp_pll;
    } row_t;

    row_t rows [8];

    task automatic run_row(input row_t r, input string tag);
        int c, fin, ndone, acc_cnt, early, pll_cnt, bad;
        stall_addr = (r.stall_e >= 0) ? taddr[r.stall_e] : 6'h3F;
        err_addr   = (r.err_e   >= 0) ? taddr[r.err_e]   : 6'h3F;
        cor_addr   = (r.cor_e   >= 0) ? taddr[r.cor_e]   : 6'h3F;
        wlog.delete();
        @(negedge clk);
        start = 1'b1;
        lock  = 1'b0;
        c = 0; fin = -1; ndone = 0; acc_cnt = 0; early = 0; pll_cnt = 0;
        while (c < 2000) begin
            @(negedge clk);
            c++;
            start  = 1'b0;
            tbl_we = 1'b0;
            if (c == 1) chk({tag, " busy_rise"}, busy, 1);
            if (done) ndone++;
            if (fin < 0 && (done || err)) fin = c;
            if (apb.PSEL && apb.PENABLE && apb.PWRITE && apb.PADDR == taddr[2]) acc_cnt++;
            if (pll && apb.PSEL) early++;
            if (r.poke != 0 && c == 3) begin
                start    = 1'b1;
                tbl_we   = 1'b1;
                tbl_idx  = 5'd0;
                tbl_addr = 6'h3E;
                tbl_data = 8'hEE;
            end
            if (pll) begin
                lock = (pll_cnt >= r.ld) && (pll_cnt != r.glitch);
                pll_cnt++;
            end else begin
                lock    = 1'b0;
                pll_cnt = 0;
            end
            if (fin >= 0 && !busy) break;
        end
        chk({tag, " finish_cycle"}, fin, r.exp_cyc);
        chk({tag, " done_pulses"}, ndone, r.exp_done);
        chk({tag, " err"}, err, (r.exp_code != 0) ? 1 : 0);
        chk({tag, " err_code"}, err_code, r.exp_code);
        chk({tag, " pll_arst_n"}, pll, r.exp_pll);
        chk({tag, " busy_end"}, busy, 0);
        chk({tag, " writes"}, wlog.size(), r.exp_wr);
        bad = 0;
        for (int k = 0; k < wlog.size() && k < NR; k++)
            if (wlog[k] !== {taddr[k], tdata[k]}) bad++;
        chk({tag, " write_order"}, bad, 0);
        chk({tag, " stall_access"}, acc_cnt, r.exp_acc);
        chk({tag, " pll_during_apb"}, early, 0);
    endtask

    initial begin
        int w;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < NR; i++) begin
            taddr[i] = 6'(i * 5 + 3);
            tdata[i] = 8'(8'h5A + i * 37);
        end
        //            stall err cor ld     glitch poke done code cyc         wr  acc pll
        rows[0] = '{-1, -1, -1, 10,    -1,    0,   1,   0,   109 + VX,   8,  1,  1};
        rows[1] = '{ 2, -1, -1, 10,    -1,    0,   1,   0,   112 + VX,   8,  4,  1};
        rows[2] = '{-1,  5, -1, 10,    -1,    0,   0,   1,   29,         5,  1,  0};
        rows[3] = '{-1, -1, -1, 10,    50,    0,   1,   0,   150 + VX,   8,  1,  1};
        rows[4] = '{-1, -1, -1, NEVER, -1,    0,   0,   2,   333 + VX,   8,  1,  0};
`ifdef CCC_RECFG_VERIFY_EN
        rows[5] = '{-1, -1,  3, 10,    -1,    0,   0,   3,   41,         8,  1,  0};
`else
        rows[5] = '{-1, -1,  3, 10,    -1,    0,   1,   0,   109,        8,  1,  1};
`endif
        rows[6] = '{-1, -1, -1, 0,     -1,    0,   1,   0,   99 + VX,    8,  1,  1};
        rows[7] = '{-1, -1, -1, 10,    -1,    1,   1,   0,   109 + VX,   8,  1,  1};

        rst_n = 1'b0; tbl_we = 1'b0; tbl_idx = '0; tbl_addr = '0; tbl_data = '0;
        start = 1'b0; lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst err_code", err_code, 0);
        chk("rst psel", apb.PSEL, 0);
        chk("rst penable", apb.PENABLE, 0);
        chk("rst pwrite", apb.PWRITE, 0);
        chk("rst paddr", apb.PADDR, 0);
        chk("rst pwdata", apb.PWDATA, 0);
        chk("rst pll", pll, 0);

        for (int i = 0; i < NR; i++) begin
            tbl_we = 1'b1; tbl_idx = 5'(i); tbl_addr = taddr[i]; tbl_data = tdata[i];
            @(negedge clk);
        end
        // Out-of-range indices must not alias onto real entries.
        tbl_idx = 5'd8;  tbl_addr = 6'h00; tbl_data = 8'h00; @(negedge clk);
        tbl_idx = 5'd16; tbl_addr = 6'h01; tbl_data = 8'h11; @(negedge clk);
        tbl_we = 1'b0;

        for (int i = 0; i < 8; i++) run_row(rows[i], $sformatf("row%0d", i));

        // Reset asserted in the middle of a write access.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!apb.PENABLE && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("midrst reached_access", apb.PENABLE, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst psel", apb.PSEL, 0);
        chk("midrst penable", apb.PENABLE, 0);
        chk("midrst busy", busy, 0);
        chk("midrst pll", pll, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_row(rows[0], "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
